fifo_sync_param: RTL and testbench



---
 rtl/fifo_sync_param.sv | 213 +++++++++++++++++++++
 tb/tb_fifo_sync_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds
// and standard or first-word-fall-through read mode. Optional macro: FIFO_ERR_FLAGS_EN.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_write_en,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_read_en,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_valid,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_almost_full,
  output logic                         o_almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                         o_overflow,
  output logic                         o_underflow,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
    $error("fifo_sync_param: AF_THRESH must be <= DEPTH and AE_THRESH < DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_inc_s;
  logic [PW-1:0]         rd_inc_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  af_r;
  logic                  ae_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] data_nxt_s;
  logic                  valid_r;
  logic                  valid_nxt_s;

  // Accept logic, pointer increments with explicit wrap, and next occupancy
  always_comb begin
    rd_acc_s = i_read_en && !empty_r;
    wr_acc_s = i_write_en && (!full_r || rd_acc_s);
    if (wr_ptr_r == PTR_LAST) begin
      wr_inc_s = '0;
    end else begin
      wr_inc_s = wr_ptr_r + PW'(1);
    end
    if (rd_ptr_r == PTR_LAST) begin
      rd_inc_s = '0;
    end else begin
      rd_inc_s = rd_ptr_r + PW'(1);
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Next read-port value: popped entry in standard mode, upcoming head in FWFT mode
  always_comb begin
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;
    if (FWFT == 0) begin
      valid_nxt_s = rd_acc_s;
      if (rd_acc_s) begin
        data_nxt_s = mem_r[rd_ptr_r];
      end else begin
        data_nxt_s = data_r;
      end
    end else begin
      valid_nxt_s = (count_nxt_s != CW'(0));
      // With one entry left, a pop plus push makes the incoming word the new head
      if (empty_r && wr_acc_s) begin
        data_nxt_s = i_data;
      end else if (rd_acc_s && (count_r == CW'(1)) && wr_acc_s) begin
        data_nxt_s = i_data;
      end else if (rd_acc_s && (count_r != CW'(1))) begin
        data_nxt_s = mem_r[rd_inc_s];
      end else begin
        data_nxt_s = data_r;
      end
    end
  end

  // Storage array; contents intentionally survive reset
  always_ff @(posedge i_clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointers, count, registered flags and read port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= (AF_THRESH == 0);
      ae_r     <= 1'b1;
      data_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_inc_s;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_inc_s;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CW'(0));
      af_r    <= (count_nxt_s >= AF_LVL);
      ae_r    <= (count_nxt_s <= AE_LVL);
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_r;
  logic udf_r;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (i_write_en && full_r && !rd_acc_s) begin
        ovf_r <= 1'b1;
      end
      if (i_read_en && empty_r) begin
        udf_r <= 1'b1;
      end
    end
  end

  assign o_overflow  = ovf_r;
  assign o_underflow = udf_r;

  fifo_sync_param_chk #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .PW    (PW)
  ) u_chk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .count   (count_r),
    .wr_ptr  (wr_ptr_r),
    .rd_ptr  (rd_ptr_r),
    .full    (full_r),
    .empty   (empty_r)
  );
`endif

  assign o_data         = data_r;
  assign o_valid        = valid_r;
  assign o_full         = full_r;
  assign o_empty        = empty_r;
  assign o_almost_full  = af_r;
  assign o_almost_empty = ae_r;
  assign o_count        = count_r;

endmodule

`ifdef FIFO_ERR_FLAGS_EN
// Structural invariants of the FIFO bookkeeping
module fifo_sync_param_chk #(
  parameter int DEPTH = 32,
  parameter int CW    = 6,
  parameter int PW    = 5
) (
  input logic          i_clk,
  input logic          i_rst_n,
  input logic [CW-1:0] count,
  input logic [PW-1:0] wr_ptr,
  input logic [PW-1:0] rd_ptr,
  input logic          full,
  input logic          empty
);

  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count <= CW'(DEPTH));

  a_full_empty_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(full && empty));

  a_count_ptr_diff: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (int'(count) % DEPTH) == ((int'(wr_ptr) + DEPTH - int'(rd_ptr)) % DEPTH));

endmodule
`endif

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: standard-mode DEPTH=5, FWFT DEPTH=5, thresholds DEPTH=8.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DUT A: DEPTH 5, standard mode, default thresholds (AF=3, AE=2)
  logic       a_wr = 1'b0, a_rd = 1'b0;
  logic [7:0] a_din = 8'h00, a_dout;
  logic       a_valid, a_full, a_empty, a_af, a_ae;
  logic [2:0] a_cnt;
  // DUT B: DEPTH 5, FWFT
  logic       b_wr = 1'b0, b_rd = 1'b0;
  logic [7:0] b_din = 8'h00, b_dout;
  logic       b_valid, b_full, b_empty, b_af, b_ae;
  logic [2:0] b_cnt;
  // DUT C: DEPTH 8, AF 6, AE 2
  logic       c_wr = 1'b0, c_rd = 1'b0;
  logic [7:0] c_din = 8'h00, c_dout;
  logic       c_valid, c_full, c_empty, c_af, c_ae;
  logic [3:0] c_cnt;
`ifdef FIFO_ERR_FLAGS_EN
  logic a_ovf, a_udf, b_ovf, b_udf, c_ovf, c_udf;
`endif

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_write_en(a_wr), .i_data(a_din), .i_read_en(a_rd),
    .o_data(a_dout), .o_valid(a_valid), .o_full(a_full), .o_empty(a_empty),
    .o_almost_full(a_af), .o_almost_empty(a_ae),
`ifdef FIFO_ERR_FLAGS_EN
    .o_overflow(a_ovf), .o_underflow(a_udf),
`endif
    .o_count(a_cnt));

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_write_en(b_wr), .i_data(b_din), .i_read_en(b_rd),
    .o_data(b_dout), .o_valid(b_valid), .o_full(b_full), .o_empty(b_empty),
    .o_almost_full(b_af), .o_almost_empty(b_ae),
`ifdef FIFO_ERR_FLAGS_EN
    .o_overflow(b_ovf), .o_underflow(b_udf),
`endif
    .o_count(b_cnt));

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_write_en(c_wr), .i_data(c_din), .i_read_en(c_rd),
    .o_data(c_dout), .o_valid(c_valid), .o_full(c_full), .o_empty(c_empty),
    .o_almost_full(c_af), .o_almost_empty(c_ae),
`ifdef FIFO_ERR_FLAGS_EN
    .o_overflow(c_ovf), .o_underflow(c_udf),
`endif
    .o_count(c_cnt));

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         cnt;
    logic       valid;
    logic [7:0] dout;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] q[$];
  logic [7:0] exp_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic wr, input logic rd, input logic [7:0] din, input int cnt,
                         input logic valid, input logic [7:0] dout, input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
    v.valid = valid; v.dout = dout; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset held for 3 cycles, then idle
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d_a_empty", i), a_empty, 1);
      check($sformatf("rst%0d_a_count", i), a_cnt, 0);
      check($sformatf("rst%0d_a_valid", i), a_valid, 0);
    end
    check("rst_a_full", a_full, 0);
    check("rst_a_ae", a_ae, 1);
    check("rst_a_af", a_af, 0);
    check("rst_a_data", a_dout, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_c_ae", c_ae, 1);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_a_empty", a_empty, 1);
    check("idle_a_count", a_cnt, 0);
    check("idle_a_valid", a_valid, 0);

    // Fill, overflow, drain, empty read, simultaneous ops at empty and at full
    add_vec(1, 0, 8'h11, 1, 0, 8'h00, 0, 0);
    add_vec(1, 0, 8'h22, 2, 0, 8'h00, 0, 0);
    add_vec(1, 0, 8'h33, 3, 0, 8'h00, 0, 0);
    add_vec(1, 0, 8'h44, 4, 0, 8'h00, 0, 0);
    add_vec(1, 0, 8'h55, 5, 0, 8'h00, 0, 0);
    add_vec(1, 0, 8'h66, 5, 0, 8'h00, 1, 0);
    add_vec(0, 1, 8'h00, 4, 1, 8'h11, 1, 0);
    add_vec(0, 1, 8'h00, 3, 1, 8'h22, 1, 0);
    add_vec(0, 1, 8'h00, 2, 1, 8'h33, 1, 0);
    add_vec(0, 1, 8'h00, 1, 1, 8'h44, 1, 0);
    add_vec(0, 1, 8'h00, 0, 1, 8'h55, 1, 0);
    add_vec(0, 0, 8'h00, 0, 0, 8'h55, 1, 0);
    add_vec(0, 1, 8'h00, 0, 0, 8'h55, 1, 1);
    add_vec(1, 1, 8'h77, 1, 0, 8'h55, 1, 1);
    add_vec(1, 0, 8'h88, 2, 0, 8'h55, 1, 1);
    add_vec(1, 0, 8'h99, 3, 0, 8'h55, 1, 1);
    add_vec(1, 0, 8'hAA, 4, 0, 8'h55, 1, 1);
    add_vec(1, 0, 8'hBB, 5, 0, 8'h55, 1, 1);
    add_vec(1, 1, 8'hCC, 5, 1, 8'h77, 1, 1);
    add_vec(0, 1, 8'h00, 4, 1, 8'h88, 1, 1);
    add_vec(0, 1, 8'h00, 3, 1, 8'h99, 1, 1);
    add_vec(0, 1, 8'h00, 2, 1, 8'hAA, 1, 1);
    add_vec(0, 1, 8'h00, 1, 1, 8'hBB, 1, 1);
    add_vec(0, 1, 8'h00, 0, 1, 8'hCC, 1, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      a_wr = vecs[i].wr; a_rd = vecs[i].rd; a_din = vecs[i].din;
      tick();
      check($sformatf("v%0d_count", i), a_cnt, vecs[i].cnt);
      check($sformatf("v%0d_full", i), a_full, (vecs[i].cnt == 5));
      check($sformatf("v%0d_empty", i), a_empty, (vecs[i].cnt == 0));
      check($sformatf("v%0d_af", i), a_af, (vecs[i].cnt >= 3));
      check($sformatf("v%0d_ae", i), a_ae, (vecs[i].cnt <= 2));
      check($sformatf("v%0d_valid", i), a_valid, vecs[i].valid);
      check($sformatf("v%0d_data", i), a_dout, vecs[i].dout);
`ifdef FIFO_ERR_FLAGS_EN
      check($sformatf("v%0d_ovf", i), a_ovf, vecs[i].ovf);
      check($sformatf("v%0d_udf", i), a_udf, vecs[i].udf);
`endif
    end
    a_wr = 1'b0; a_rd = 1'b0;

    // Wrap-around: 4 rounds of 3 writes then 3 reads
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int k = 1; k <= 3; k++) begin
        a_wr = 1'b1; a_din = 8'((r + 1) * 16 + k);
        q.push_back(a_din);
        tick();
      end
      a_wr = 1'b0;
      check($sformatf("wrap%0d_count", r), a_cnt, 3);
      for (int k = 0; k < 3; k++) begin
        a_rd = 1'b1;
        tick();
        exp_d = q.pop_front();
        check($sformatf("wrap%0d_valid%0d", r, k), a_valid, 1);
        check($sformatf("wrap%0d_data%0d", r, k), a_dout, exp_d);
      end
      a_rd = 1'b0;
      check($sformatf("wrap%0d_empty", r), a_empty, 1);
    end

    // Reset mid-operation discards entries without waiting for a clock edge
    a_wr = 1'b1; a_din = 8'h5C;
    repeat (2) tick();
    a_wr = 1'b0;
    check("midrst_pre_count", a_cnt, 2);
    rst_n = 1'b0;
    #2;
    check("midrst_count", a_cnt, 0);
    check("midrst_empty", a_empty, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_after_count", a_cnt, 0);

    // FWFT mode
    b_wr = 1'b1; b_din = 8'hA5;
    tick();
    b_wr = 1'b0;
    check("fwft_wr_valid", b_valid, 1);
    check("fwft_wr_data", b_dout, 8'hA5);
    tick();
    check("fwft_hold_data", b_dout, 8'hA5);
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    check("fwft_pop_valid", b_valid, 0);
    check("fwft_pop_empty", b_empty, 1);
    b_wr = 1'b1; b_din = 8'h10;
    tick();
    check("fwft_w10_data", b_dout, 8'h10);
    b_rd = 1'b1; b_din = 8'h20;
    tick();
    check("fwft_rw1_count", b_cnt, 1);
    check("fwft_rw1_valid", b_valid, 1);
    check("fwft_rw1_data", b_dout, 8'h20);
    b_rd = 1'b0; b_din = 8'h30;
    tick();
    b_wr = 1'b0;
    check("fwft_w30_data", b_dout, 8'h20);
    check("fwft_w30_count", b_cnt, 2);
    b_rd = 1'b1;
    tick();
    check("fwft_next_data", b_dout, 8'h30);
    tick();
    b_rd = 1'b0;
    check("fwft_last_valid", b_valid, 0);
    check("fwft_last_empty", b_empty, 1);

    // Thresholds on DEPTH 8, AF 6, AE 2
    check("thr0_af", c_af, 0);
    check("thr0_ae", c_ae, 1);
    for (int i = 1; i <= 6; i++) begin
      c_wr = 1'b1; c_din = 8'(i);
      tick();
      check($sformatf("thr_w%0d_count", i), c_cnt, i);
      check($sformatf("thr_w%0d_af", i), c_af, (i == 6));
      check($sformatf("thr_w%0d_ae", i), c_ae, (i <= 2));
    end
    c_wr = 1'b0;
    for (int i = 5; i >= 2; i--) begin
      c_rd = 1'b1;
      tick();
      check($sformatf("thr_r%0d_count", i), c_cnt, i);
      check($sformatf("thr_r%0d_af", i), c_af, 0);
      check($sformatf("thr_r%0d_ae", i), c_ae, (i == 2));
    end
    c_rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
